// File: rtl/serial_deserializer.sv
// Serial-to-parallel receive stage: frames an MSB-first bit stream into NBIT-bit
// words on a start marker and holds each word in a single-entry valid/ready register.
module serial_deserializer #(
    parameter int NBIT = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_s_data,
    input  logic            i_s_valid,
    input  logic            i_s_start,
    output logic [NBIT-1:0] o_q,
    output logic            o_q_valid,
    input  logic            i_q_ready,
    output logic            o_busy,
    output logic            o_ovf,
    output logic            o_frm_err,
    input  logic            i_clr
);

    localparam int CW = $clog2(NBIT);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NBIT-1:0] shreg_q, shreg_d;
    logic [NBIT-1:0] q_q, q_d;
    logic            q_valid_q, q_valid_d;
    logic            ovf_q, ovf_d;
    logic            frm_err_q, frm_err_d;

    logic [NBIT-1:0] word;
    logic            complete;
    logic            frm_set;
    logic            ovf_set;

    assign word = {shreg_q[NBIT-2:0], i_s_data};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        complete  = 1'b0;
        frm_set   = 1'b0;
        ovf_set   = 1'b0;

        if (i_s_valid) begin
            shreg_d = word;
            unique case (state_q)
                IDLE: begin
                    if (i_s_start) begin
                        state_d = SHIFT;
                        cnt_d   = CW'(1);
                    end
                end
                SHIFT: begin
                    if (i_s_start) begin
                        frm_set = 1'b1;
                        cnt_d   = CW'(1);
                    end else if (cnt_q == CW'(NBIT - 1)) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end

        // A drain in the same cycle frees the register for the completing word.
        if (complete) begin
            if (!q_valid_q || i_q_ready) begin
                q_d       = word;
                q_valid_d = 1'b1;
            end else begin
                ovf_set = 1'b1;
            end
        end else if (q_valid_q && i_q_ready) begin
            q_valid_d = 1'b0;
        end

        ovf_d     = (ovf_q && !i_clr) || ovf_set;
        frm_err_d = (frm_err_q && !i_clr) || frm_set;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            ovf_q     <= ovf_d;
            frm_err_q <= frm_err_d;
        end
    end

    assign o_q       = q_q;
    assign o_q_valid = q_valid_q;
    assign o_busy    = (state_q == SHIFT);
    assign o_ovf     = ovf_q;
    assign o_frm_err = frm_err_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer (NBIT=8) with a word-level reference model
// compared against every output on every falling edge.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_data = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_start = 1'b0;
    logic       q_ready = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] q;
    logic       q_valid;
    logic       busy;
    logic       ovf;
    logic       frm_err;

    int n_vec = 0;
    int n_err = 0;

    serial_deserializer #(.NBIT(8)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_s_data  (s_data),
        .i_s_valid (s_valid),
        .i_s_start (s_start),
        .o_q       (q),
        .o_q_valid (q_valid),
        .i_q_ready (q_ready),
        .o_busy    (busy),
        .o_ovf     (ovf),
        .o_frm_err (frm_err),
        .i_clr     (clr)
    );

    always #5 clk = ~clk;

    // Reference model: bits collected so far as an integer plus a count (0 = idle).
    int         m_word = 0;
    int         m_n = 0;
    logic [7:0] m_q = 8'h00;
    logic       m_qv = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_frm = 1'b0;

    always @(posedge clk) begin
        bit         done;
        bit         set_ovf;
        bit         set_frm;
        logic [7:0] fin;
        done = 0; set_ovf = 0; set_frm = 0; fin = 8'h00;
        if (rst) begin
            m_word = 0; m_n = 0; m_q = 8'h00; m_qv = 1'b0; m_ovf = 1'b0; m_frm = 1'b0;
        end else begin
            if (s_valid) begin
                if (s_start) begin
                    if (m_n > 0) set_frm = 1;
                    m_word = int'(s_data);
                    m_n = 1;
                end else if (m_n > 0) begin
                    m_word = m_word * 2 + int'(s_data);
                    m_n = m_n + 1;
                    if (m_n == 8) begin
                        done = 1;
                        fin = 8'(m_word);
                        m_n = 0;
                    end
                end
            end
            if (done) begin
                if (!m_qv || q_ready) begin
                    m_q = fin;
                    m_qv = 1'b1;
                end else begin
                    set_ovf = 1;
                end
            end else if (m_qv && q_ready) begin
                m_qv = 1'b0;
            end
            if (clr) begin m_ovf = 1'b0; m_frm = 1'b0; end
            if (set_ovf) m_ovf = 1'b1;
            if (set_frm) m_frm = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model_q",     q,           m_q);
        chk("model_valid", 8'(q_valid), 8'(m_qv));
        chk("model_busy",  8'(busy),    8'(m_n > 0));
        chk("model_ovf",   8'(ovf),     8'(m_ovf));
        chk("model_frm",   8'(frm_err), 8'(m_frm));
    end

    task automatic step(input logic v, input logic d, input logic s);
        s_valid = v;
        s_data  = d;
        s_start = s;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy_last);
        logic [7:0] wv;
        wv = w;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) q_ready = rdy_last;
            step(1'b1, wv[i], i == 7);
        end
        s_valid = 1'b0;
        s_start = 1'b0;
    endtask

    initial begin
        logic [7:0] gw;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_q",     q,           8'h00);
        chk("rst_valid", 8'(q_valid), 8'd0);
        chk("rst_busy",  8'(busy),    8'd0);

        // Basic word
        q_ready = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        chk("basic_busy_bit1", 8'(busy), 8'd1);
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
        chk("basic_busy_bit7", 8'(busy), 8'd1);
        step(1'b1, 1'b1, 1'b0);
        chk("basic_q",     q,           8'hA5);
        chk("basic_valid", 8'(q_valid), 8'd1);
        chk("basic_busy",  8'(busy),    8'd0);
        chk("model_pin_a5", m_q,        8'hA5);
        step(1'b0, 1'b0, 1'b0);
        chk("basic_drain", 8'(q_valid), 8'd0);

        // Stray bits while idle, then gapped word
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
        chk("idle_ignore_busy", 8'(busy), 8'd0);
        gw = 8'h3C;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, gw[i], i == 7);
            if (i != 0) begin
                step(1'b0, 1'b1, 1'b1);
                step(1'b0, 1'b0, 1'b0);
                chk("gap_busy", 8'(busy), 8'd1);
            end
        end
        s_valid = 1'b0;
        chk("gap_q",   q,           8'h3C);
        chk("gap_ovf", 8'(ovf),     8'd0);
        chk("gap_frm", 8'(frm_err), 8'd0);
        step(1'b0, 1'b0, 1'b0);

        // Backpressure and overflow
        q_ready = 1'b0;
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        chk("bp_q",     q,           8'h11);
        chk("bp_valid", 8'(q_valid), 8'd1);
        chk("bp_ovf",   8'(ovf),     8'd1);
        q_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("bp_drain", 8'(q_valid), 8'd0);
        clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        chk("bp_clr_ovf", 8'(ovf), 8'd0);

        // Drain coinciding with completion
        q_ready = 1'b0;
        send_word(8'h11, 1'b0);
        send_word(8'h5A, 1'b1);
        chk("sim_q",     q,           8'h5A);
        chk("sim_valid", 8'(q_valid), 8'd1);
        chk("sim_ovf",   8'(ovf),     8'd0);
        step(1'b0, 1'b0, 1'b0);

        // Framing error
        step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b0, 1'b0); step(1'b1, 1'b1, 1'b0);
        chk("frm_before", 8'(frm_err), 8'd0);
        gw = 8'hF0;
        step(1'b1, gw[7], 1'b1);
        chk("frm_set", 8'(frm_err), 8'd1);
        for (int i = 6; i >= 0; i--) step(1'b1, gw[i], 1'b0);
        chk("frm_q",     q,           8'hF0);
        chk("frm_valid", 8'(q_valid), 8'd1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        clr = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        clr = 1'b0;
        chk("frm_set_wins", 8'(frm_err), 8'd1);
        clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        chk("frm_clr", 8'(frm_err), 8'd0);

        // Reset mid-word
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst2_q",     q,           8'h00);
        chk("rst2_valid", 8'(q_valid), 8'd0);
        chk("rst2_busy",  8'(busy),    8'd0);
        chk("rst2_ovf",   8'(ovf),     8'd0);
        chk("rst2_frm",   8'(frm_err), 8'd0);
        send_word(8'h81, 1'b1);
        chk("rst2_word", q,           8'h81);
        chk("rst2_v",    8'(q_valid), 8'd1);
        chk("rst2_flag", 8'(ovf | frm_err), 8'd0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-to-parallel receive stage placed directly downstream of the parallel-load shift register. It consumes that register's MSB-first serial output, frames it into NBIT-bit words using a start marker, and presents each completed word on a single-entry valid/ready output register. Framing errors and dropped words are flagged with sticky status bits.

## Interface

- NBIT, 8, word width in bits; legal range is NBIT >= 2.
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst  in  1  reset; synchronous and active-high.
- i_s_data  in  1  serial data bit, MSB of each word first.
- i_s_valid  in  1  i_s_data is meaningful this cycle.
- i_s_start  in  1  marks the first (MSB) bit of a word; qualified by i_s_valid.
- o_q  out  NBIT  last accepted word; bit NBIT-1 is the first bit received.
- o_q_valid  out  1  o_q holds an unconsumed word.
- i_q_ready  in  1  consumer accepts o_q when o_q_valid && i_q_ready.
- o_busy  out  1  a word is partially collected (state SHIFT).
- o_ovf  out  1  sticky: a completed word was dropped because the output register was full.
- o_frm_err  out  1  sticky: a start arrived mid-word and the partial word was discarded.
- i_clr  in  1  one-cycle pulse that clears o_ovf and o_frm_err.

## Operation

- Bit accept: a bit is taken only on a cycle with i_s_valid=1. Cycles with i_s_valid=0 hold all state, with no timeout.
- Shift: shreg <= {shreg[NBIT-2:0], i_s_data} on every accepted bit. The counter cnt has width $clog2(NBIT) and runs 0..NBIT-1.
- FSM IDLE: accepted bits without i_s_start are ignored.
  - i_s_valid && i_s_start moves to SHIFT.
  - The bit is captured and cnt becomes 1.
- FSM SHIFT, accepted bit without start: shift and increment cnt.
  - When the bit is the NBIT-th one (cnt == NBIT-1), the word completes.
  - On completion, return to IDLE and clear cnt to 0.
- FSM SHIFT, accepted bit with start: the partial word is discarded and o_frm_err is set.
  - That bit becomes bit 1 of a new word, with cnt = 1.
  - The FSM stays in SHIFT.
- Word completion, output register free: the register is free when o_q_valid=0, or when o_q_valid && i_q_ready in the same cycle.
  - In that case, o_q <= {shreg[NBIT-2:0], i_s_data} and o_q_valid <= 1.
- Word completion, output register full: the register is full when o_q_valid=1 and i_q_ready=0.
  - The new word is dropped, o_q keeps the old word, and o_ovf <= 1.
- Drain: on o_q_valid && i_q_ready with no completion that cycle, o_q_valid <= 0. o_q retains its stale value.
- Sticky flags: i_clr clears o_ovf and o_frm_err. If a set condition and i_clr occur in the same cycle, the set wins.
- Reset (i_rst=1 at an edge) forces the following, with priority over all other inputs:
  - state = IDLE, cnt = 0, shreg = 0;
  - o_q = 0, o_q_valid = 0, o_busy = 0;
  - o_ovf = 0, o_frm_err = 0.
- Reset mid-word discards the partial word. Reset with o_q_valid=1 drops the held word silently and does not set o_ovf.

## Timing

- All outputs are registered; o_busy is decoded from the state register.
- Latency: the NBIT-th accepted bit is sampled at edge T, and o_q/o_q_valid are valid after edge T.
  - The consumer sees the word in the cycle following the last bit.
- Throughput: back-to-back words (start on the bit immediately after a completion) are supported at 1 bit/cycle with no idle gap.
- A minimum word takes NBIT accepted bits. The earliest next start is the cycle right after the completing bit.
- Handshake: o_q and o_q_valid are stable while o_q_valid=1 and i_q_ready=0. i_q_ready may be asserted while o_q_valid=0, with no effect.
- o_ovf and o_frm_err rise on the edge following the event and stay high until i_clr or i_rst.

## Test plan

- Basic word (NBIT=8): reset, then 8 consecutive accepted bits of 8'hA5 MSB first, start on the first bit, i_q_ready=1.
  - o_q=8'hA5 with o_q_valid high for exactly 1 cycle, starting the cycle after bit 8.
  - o_busy is high for bits 1-7 cycles.
- Gapped input: send 8'h3C with i_s_valid=0 for 2 cycles between every bit.
  - Result is o_q=8'h3C and no flags.
  - o_busy stays high across the gaps.
  - Bits offered with i_s_valid=1 while IDLE and without start are ignored.
- Backpressure: with i_q_ready=0, send 8'h11 then back-to-back 8'h22.
  - o_q stays 8'h11 with o_q_valid=1, and o_ovf=1 from the cycle after 8'h22 completes.
  - Then raise i_q_ready: 8'h11 is consumed once and o_q_valid drops.
  - Pulse i_clr: o_ovf returns to 0.
- Simultaneous drain and completion: hold 8'h11 valid, then assert i_q_ready exactly on the cycle the 8'h5A word completes.
  - o_q becomes 8'h5A, o_q_valid stays 1, and o_ovf stays 0.
- Framing error: send 3 bits, then restart with start on 8'hF0.
  - o_frm_err=1 the cycle after the restart bit, and the output word is 8'hF0.
  - Then assert i_clr on the same cycle as another framing error: o_frm_err stays 1.
- Reset mid-operation: send 5 bits, assert i_rst for 1 cycle, then send the full word 8'h81.
  - After reset all outputs are 0.
  - Result is o_q=8'h81 with no residue from the aborted word and no flags.
